// File: rtl/l2_flush_engine_pkg.sv
// Shared types for the L2 flush walker: per-word state encodings, FSM state enum,
// default geometry and a width helper.
package l2_flush_engine_pkg;

    localparam int L2_SETS_DEFAULT        = 512;
    localparam int L2_WAYS_DEFAULT        = 8;
    localparam int WORDS_PER_LINE_DEFAULT = 2;
    localparam int STATE_W_DEFAULT        = 2;

    localparam int ST_I = 0;
    localparam int ST_V = 1;
    localparam int ST_S = 2;
    localparam int ST_O = 3;

    typedef enum logic [2:0] {
        FL_IDLE,
        FL_READ,
        FL_EVAL,
        FL_SCAN,
        FL_DONE
    } l2_flush_state_t;

    // Index width that stays at least one bit for single-entry arrays.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/l2_flush_engine_if.sv
// Flush command, local-memory read/write and writeback request bundle of the L2 flush walker.
// valid/ready: a transfer happens in a cycle where both are 1; the sender holds its payload stable while valid=1 and ready=0.
interface l2_flush_engine_if
    import l2_flush_engine_pkg::*;
#(
    parameter int L2_SETS        = L2_SETS_DEFAULT,
    parameter int L2_WAYS        = L2_WAYS_DEFAULT,
    parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEFAULT,
    parameter int STATE_W        = STATE_W_DEFAULT
);
    localparam int SET_W = clog2_min1(L2_SETS);
    localparam int WAY_W = clog2_min1(L2_WAYS);

    logic                                      flush_valid;
    logic                                      flush_ready;
    logic                                      flush_is_all;
    logic                                      lmem_rd_en;
    logic [SET_W-1:0]                          lmem_rd_set;
    logic [L2_WAYS*WORDS_PER_LINE*STATE_W-1:0] lmem_rd_state;
    logic                                      wb_valid;
    logic                                      wb_ready;
    logic [SET_W-1:0]                          wb_set;
    logic [WAY_W-1:0]                          wb_way;
    logic [WORDS_PER_LINE-1:0]                 wb_word_mask;
    logic                                      lmem_wr_en;
    logic [SET_W-1:0]                          lmem_wr_set;
    logic [WAY_W-1:0]                          lmem_wr_way;
    logic [WORDS_PER_LINE-1:0]                 lmem_wr_word_mask;

    modport master (
        input  flush_valid, flush_is_all, lmem_rd_state, wb_ready,
        output flush_ready, lmem_rd_en, lmem_rd_set, wb_valid, wb_set, wb_way,
               wb_word_mask, lmem_wr_en, lmem_wr_set, lmem_wr_way, lmem_wr_word_mask
    );

    modport slave (
        output flush_valid, flush_is_all, lmem_rd_state, wb_ready,
        input  flush_ready, lmem_rd_en, lmem_rd_set, wb_valid, wb_set, wb_way,
               wb_word_mask, lmem_wr_en, lmem_wr_set, lmem_wr_way, lmem_wr_word_mask
    );

endinterface

// File: rtl/l2_flush_engine_mask.sv
// l2_flush_mask: per-way owned-word and invalidate-word masks for the flush walker.
module l2_flush_mask
    import l2_flush_engine_pkg::*;
#(
    parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEFAULT,
    parameter int STATE_W        = STATE_W_DEFAULT
) (
    input  logic [WORDS_PER_LINE*STATE_W-1:0] way_state,
    input  logic                              mode_all,
    output logic [WORDS_PER_LINE-1:0]         own_mask,
    output logic [WORDS_PER_LINE-1:0]         inv_mask
);

    always_comb begin
        own_mask = '0;
        inv_mask = '0;
        for (int w = 0; w < WORDS_PER_LINE; w++) begin
            own_mask[w] = (way_state[w*STATE_W +: STATE_W] == STATE_W'(ST_O));
            inv_mask[w] = mode_all ? (way_state[w*STATE_W +: STATE_W] != STATE_W'(ST_I))
                                   : (way_state[w*STATE_W +: STATE_W] == STATE_W'(ST_O));
        end
    end

endmodule

// File: rtl/l2_flush_engine.sv
// L2 flush walker: visits every set/way, writes back owned words and invalidates per flush mode.
// Optional L2_FLUSH_STATS_EN adds saturating writeback and stall counters.
module l2_flush_engine
    import l2_flush_engine_pkg::*;
#(
    parameter int   L2_SETS        = L2_SETS_DEFAULT,
    parameter int   L2_WAYS        = L2_WAYS_DEFAULT,
    parameter int   WORDS_PER_LINE = WORDS_PER_LINE_DEFAULT,
    parameter int   STATE_W        = STATE_W_DEFAULT,
    localparam int  SET_W          = clog2_min1(L2_SETS),
    localparam int  WAY_W          = clog2_min1(L2_WAYS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_in,
    l2_flush_engine_if.master bus,
    output logic            busy,
    output logic            flush_done,
    output l2_flush_state_t dbg_state
`ifdef L2_FLUSH_STATS_EN
    ,
    output logic [15:0]     stat_wb_cnt,
    output logic [15:0]     stat_stall_cnt
`endif
);

    localparam int LINE_W = WORDS_PER_LINE * STATE_W;
    localparam int ALL_W  = L2_WAYS * LINE_W;

    l2_flush_state_t           state_q, state_d;
    logic [SET_W:0]            set_q, set_d;
    logic [WAY_W:0]            way_q, way_d;
    logic                      mode_q, mode_d;
    logic [ALL_W-1:0]          buf_q, buf_d;
    logic [LINE_W-1:0]         cur_line;
    logic [WORDS_PER_LINE-1:0] own_mask, inv_mask;
    logic                      last_way, last_set, advance;
    logic                      rd_en, wb_valid, wr_en;

    assign cur_line = buf_q[int'(way_q[WAY_W-1:0])*LINE_W +: LINE_W];
    assign last_way = (way_q == (WAY_W+1)'(L2_WAYS - 1));
    // Counter is one bit wider than the index so the compare works for any set count.
    assign last_set = ((set_q + 1'b1) == (SET_W+1)'(L2_SETS));

    l2_flush_mask #(
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .STATE_W        (STATE_W)
    ) u_mask (
        .way_state (cur_line),
        .mode_all  (mode_q),
        .own_mask  (own_mask),
        .inv_mask  (inv_mask)
    );

    always_comb begin
        state_d  = state_q;
        set_d    = set_q;
        way_d    = way_q;
        mode_d   = mode_q;
        buf_d    = buf_q;
        rd_en    = 1'b0;
        wb_valid = 1'b0;
        wr_en    = 1'b0;
        advance  = 1'b0;
        case (state_q)
            FL_IDLE: begin
                if (bus.flush_valid) begin
                    mode_d  = bus.flush_is_all;
                    set_d   = '0;
                    way_d   = '0;
                    state_d = FL_READ;
                end
            end
            FL_READ: begin
                if (!stall_in) begin
                    rd_en   = 1'b1;
                    state_d = FL_EVAL;
                end
            end
            FL_EVAL: begin
                buf_d   = bus.lmem_rd_state;
                way_d   = '0;
                state_d = FL_SCAN;
            end
            FL_SCAN: begin
                // Owned words go out as a writeback; the invalidate write rides the same handshake cycle.
                if (|own_mask) begin
                    wb_valid = 1'b1;
                    if (bus.wb_ready) begin
                        wr_en   = 1'b1;
                        advance = 1'b1;
                    end
                end else begin
                    wr_en   = |inv_mask;
                    advance = 1'b1;
                end
                if (advance) begin
                    if (!last_way) begin
                        way_d = way_q + 1'b1;
                    end else if (last_set) begin
                        state_d = FL_DONE;
                    end else begin
                        set_d   = set_q + 1'b1;
                        way_d   = '0;
                        state_d = FL_READ;
                    end
                end
            end
            FL_DONE: state_d = FL_IDLE;
            default: state_d = FL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FL_IDLE;
            set_q   <= '0;
            way_q   <= '0;
            mode_q  <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            way_q   <= way_d;
            mode_q  <= mode_d;
            buf_q   <= buf_d;
        end
    end

    assign bus.flush_ready       = (state_q == FL_IDLE);
    assign bus.lmem_rd_en        = rd_en;
    assign bus.lmem_rd_set       = set_q[SET_W-1:0];
    assign bus.wb_valid          = wb_valid;
    assign bus.wb_set            = set_q[SET_W-1:0];
    assign bus.wb_way            = way_q[WAY_W-1:0];
    assign bus.wb_word_mask      = own_mask;
    assign bus.lmem_wr_en        = wr_en;
    assign bus.lmem_wr_set       = set_q[SET_W-1:0];
    assign bus.lmem_wr_way       = way_q[WAY_W-1:0];
    assign bus.lmem_wr_word_mask = inv_mask;
    assign busy                  = (state_q != FL_IDLE);
    assign flush_done            = (state_q == FL_DONE);
    assign dbg_state             = state_q;

`ifdef L2_FLUSH_STATS_EN
    logic [15:0] wb_cnt_q, wb_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        wb_cnt_d    = wb_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (state_q == FL_IDLE && bus.flush_valid) begin
            wb_cnt_d    = '0;
            stall_cnt_d = '0;
        end else begin
            if (wb_valid && bus.wb_ready && wb_cnt_q != '1)
                wb_cnt_d = wb_cnt_q + 1'b1;
            if (((state_q == FL_READ && stall_in) || (wb_valid && !bus.wb_ready))
                && stall_cnt_q != '1)
                stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            wb_cnt_q    <= wb_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stat_wb_cnt    = wb_cnt_q;
    assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/l2_flush_engine.md
# l2_flush_engine

Parametrised L2 flush walker for the Spandex L2. It walks every set and way of the L2 local memory and writes back owned words through the request path. It also invalidates lines according to the flush mode and pulses `flush_done` on completion. It sits beside `l2_fsm`, sharing the local-memory read and write ports, and replaces the tied-off flush signals in the core (`ongoing_flush`, `flush_done`, set and way counters).

## Interface
- `L2_SETS`, 512: number of sets; any value ≥1, not restricted to powers of two.
- `L2_WAYS`, 8: ways per set, ≥1.
- `WORDS_PER_LINE`, 2: words per line.
- `STATE_W`, 2: per-word state width. Encoding: I=0, V=1, S=2, O=3.
- `SET_W`, `$clog2(L2_SETS)` (minimum 1); `WAY_W`, `$clog2(L2_WAYS)` (minimum 1). Derived parameters, not to be overridden.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `flush_valid` / `flush_ready`  in / out  1  flush command handshake.
- `flush_is_all`  in  1  mode, sampled at handshake. 1 = invalidate every non-I word. 0 = invalidate owned words only.
- `stall_in`  in  1  core is busy; the engine yields before starting a set.
- `lmem_rd_en` / `lmem_rd_set`  out  1 / SET_W  set read request.
- `lmem_rd_state`  in  L2_WAYS*WORDS_PER_LINE*STATE_W  flattened states, way-major, valid 1 cycle after `lmem_rd_en`.
- `wb_valid` / `wb_ready`  out / in  1  writeback request handshake.
- `wb_set`, `wb_way`, `wb_word_mask`  out  SET_W, WAY_W, WORDS_PER_LINE  writeback target and owned-word mask.
- `lmem_wr_en`, `lmem_wr_set`, `lmem_wr_way`, `lmem_wr_word_mask`  out  1, SET_W, WAY_W, WORDS_PER_LINE  writes state I to the masked words.
- `busy`  out  1  engine is not idle.
- `flush_done`  out  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE: `flush_ready`=1. On handshake, latch the mode, clear set=0 and way=0, go to READ.
  - READ: if `stall_in`=1, hold with `lmem_rd_en`=0. Otherwise assert `lmem_rd_en` with `lmem_rd_set`=set and go to EVAL.
  - EVAL: latch all way states into the state buffer, way=0, go to SCAN.
  - SCAN: compute masks for the current way.
    - own_mask = words where the state is O.
    - inv_mask = (mode all) ? words where the state is not I : own_mask.
    - own_mask≠0: hold `wb_valid`. In the handshake cycle, assert `lmem_wr_en` with inv_mask, then advance.
    - own_mask=0 and inv_mask≠0: assert `lmem_wr_en` for one cycle, then advance.
    - Both masks zero: advance with no outputs.
  - Advance: if way=L2_WAYS-1, go to READ with set+1. If set+1=L2_SETS, go to DONE instead. Otherwise increment way.
  - DONE: `flush_done`=1 for one cycle, then go to IDLE.
- Counter widths:
  - The set counter is SET_W+1 bits; the terminal compare is against L2_SETS, so non-power-of-two set counts work.
  - The way counter is WAY_W+1 bits.
- Flush commands while busy are not accepted (`flush_ready`=0).
- `stall_in` is honoured only in READ. A set, once read, is processed atomically, and the core guarantees no conflicting write to it meanwhile.
- `wb_set`, `wb_way` and `wb_word_mask` stay stable while `wb_valid`=1 and `wb_ready`=0.

## Timing
- Reset values: all outputs 0 except `flush_ready`=1. State is IDLE and the counters are 0.
- Reset asserted mid-flush aborts immediately. No `flush_done` pulse is produced and no further writes are issued.
- If the handshake is at cycle 0, the first READ is at cycle 1. With no stalls and no writebacks, each set takes 2+L2_WAYS cycles, so `flush_done` is at cycle 1+L2_SETS*(2+L2_WAYS).
- Each cycle of `wb_ready`=0 or of `stall_in` in READ adds one cycle.
- The local-memory read latency is fixed at 1 cycle.
- `lmem_wr_en` and the writeback handshake occur in the same cycle. There is never more than one write per cycle.

## Configuration
- `L2_FLUSH_STATS_EN` defined: adds two output ports, each saturating at all-ones and cleared at flush start.
  - `stat_wb_cnt` (16): writebacks issued.
  - `stat_stall_cnt` (16): cycles in READ with `stall_in` or in SCAN with `wb_valid`&!`wb_ready`.
- `L2_FLUSH_STATS_EN` undefined: neither port nor its counter exists; behaviour is otherwise identical.

## Structure
- The state encodings (I/V/S/O) and the `l2_flush_state_t` enum belong in `spandex_types.svh`. The default parameter values come from `spandex_consts.svh`.
- Sub-module `l2_flush_mask`: combinational; takes one way's states and the mode, and produces own_mask and inv_mask. It is instantiated once on the current way.

## Test plan
- Empty cache, L2_SETS=4, L2_WAYS=2, `wb_ready`=1 → no `wb_valid`, no `lmem_wr_en`, `flush_done` at cycle 17.
- Set 2, way 1, states {O,V}, mode 0 → one writeback (set 2, way 1, mask 01) with write mask 01; V is untouched.
- Same states, mode 1 → writeback mask 01, write mask 11.
- `wb_ready` held low for 5 cycles → `wb_valid` and payload stable; `flush_done` delayed 5 cycles; `stat_stall_cnt`=5 when the stats feature is enabled.
- `stall_in`=1 for 3 cycles in READ of set 1 → no `lmem_rd_en` during the stall; `flush_done` delayed 3 cycles.
- L2_SETS=3 (non-power-of-two), plus reset during SCAN → counter terminates after set 2. After reset: IDLE, `flush_ready`=1, no `flush_done` pulse.
